// File: rtl/konwersja_pkg.sv
// Shared defaults and occupancy encoding for the conversion stage and its result buffer.
// Holds no logic; BITS must match the upstream conversion stage's word width.
package konwersja_pkg;

    localparam int BITS_DEF  = 32;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/licznik_bledow.sv
// Saturating event counter: +1 per cycle with i_inc, sticks at all-ones, sync active-high clear.
// Count visible one cycle after the increment edge; no backpressure.
module licznik_bledow
    import konwersja_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bufor_wyniku.sv
// 2-entry order-preserving skid buffer for converted words; 1-cycle latency EMPTY->head.
// o_ready depends only on registered occupancy (no path from i_ready); FULL ignores i_valid.
module bufor_wyniku
    import konwersja_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [BITS-1:0]  i_result,
    input  logic             i_error,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_result,
    output logic             o_error,
    output logic [CNT_W-1:0] o_err_count
);

    occ_t            r_state;
    occ_t            w_state_nxt;
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [BITS-1:0] r_mem_dat [2];
    logic            r_mem_err [2];
    logic            w_push;
    logic            w_pop;

    assign o_ready = (r_state != FULL);
    assign o_valid = (r_state != EMPTY);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_push) w_state_nxt = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_state_nxt = FULL;
                else if (w_pop && !w_push) w_state_nxt = EMPTY;
            end
            FULL:  if (w_pop) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem_dat[r_wr_ptr] <= i_result;
            r_mem_err[r_wr_ptr] <= i_error;
        end
    end

    assign o_result = o_valid ? r_mem_dat[r_rd_ptr] : '0;
    assign o_error  = o_valid ? r_mem_err[r_rd_ptr] : 1'b0;

    licznik_bledow #(
        .CNT_W (CNT_W)
    ) u_licznik_bledow (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_push && i_error && !i_rst),
        .o_count (o_err_count)
    );

endmodule

// File: tb/tb_bufor_wyniku.sv
// Bench for bufor_wyniku: queue-based reference model checked every cycle, directed cases, random traffic.
module tb_bufor_wyniku;

    localparam int BITS  = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_vld;
    logic [BITS-1:0]  in_dat;
    logic             in_err;
    logic             out_rdy;
    logic             o_ready;
    logic             o_valid;
    logic [BITS-1:0]  o_result;
    logic             o_error;
    logic [CNT_W-1:0] o_err_count;

    always #5 clk = ~clk;

    bufor_wyniku #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_vld),
        .i_result    (in_dat),
        .i_error     (in_err),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .i_ready     (out_rdy),
        .o_result    (o_result),
        .o_error     (o_error),
        .o_err_count (o_err_count)
    );

    // Reference: a queue of {error, word} of at most two entries plus a saturating count.
    logic [BITS:0] mq[$];
    int            mcnt;
    bit            model_ok = 1'b0;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_valid", longint'(o_valid), longint'(mq.size() > 0));
            chk("model_ready", longint'(o_ready), longint'(mq.size() < 2));
            chk("model_result", longint'(o_result), (mq.size() > 0) ? longint'(mq[0][BITS-1:0]) : 0);
            chk("model_error", longint'(o_error), (mq.size() > 0) ? longint'(mq[0][BITS]) : 0);
            chk("model_count", longint'(o_err_count), longint'(mcnt));
        end
    end

    // Called at a falling edge; drives inputs, advances the model at the rising edge, returns at the next falling edge.
    task automatic cyc(input bit r, input bit v, input logic [BITS-1:0] d, input bit e, input bit rd);
        bit push, pop;
        rst = r; in_vld = v; in_dat = d; in_err = e; out_rdy = rd;
        push = v && (mq.size() < 2);
        pop  = (mq.size() > 0) && rd;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({e, d});
                if (e && mcnt < CMAX) mcnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_dat = '0; in_err = 1'b0; out_rdy = 1'b0;
        mcnt = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        model_ok = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_result", o_result, 0);
        chk("rst_count", o_err_count, 0);

        cyc(0, 1, 32'h0000_0005, 0, 1);
        chk("lat_result", o_result, 32'h0000_0005);
        chk("lat_valid", o_valid, 1);
        cyc(0, 0, 0, 0, 1);
        chk("lat_drain", o_valid, 0);

        cyc(0, 1, 32'hAAAA_AAAA, 0, 0);
        cyc(0, 1, 32'h5555_5555, 0, 0);
        chk("full_ready", o_ready, 0);
        chk("full_head", o_result, 32'hAAAA_AAAA);
        cyc(0, 1, 32'h1234_5678, 0, 0);
        chk("full_hold", o_result, 32'hAAAA_AAAA);
        cyc(0, 0, 0, 0, 1);
        chk("full_second", o_result, 32'h5555_5555);
        cyc(0, 0, 0, 0, 1);
        chk("full_empty", o_valid, 0);

        cyc(0, 1, 32'h0000_0011, 0, 0);
        cyc(0, 1, 32'h0000_00FF, 0, 1);
        chk("pp_head", o_result, 32'h0000_00FF);
        chk("pp_ready", o_ready, 1);
        cyc(0, 0, 0, 0, 1);
        chk("pp_empty", o_valid, 0);

        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 32'h8000_0000, 1, 1);
            if (i == 0 || i == 299) chk("err_flag", o_error, 1);
        end
        cyc(0, 0, 0, 0, 1);
        chk("err_sat", o_err_count, 255);

        cyc(0, 1, 32'h0000_0001, 0, 0);
        cyc(0, 1, 32'h0000_0002, 1, 0);
        chk("rst_full_ready", o_ready, 0);
        cyc(1, 1, 32'h8000_0000, 1, 0);
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_ready", o_ready, 1);
        chk("rst_mid_count", o_err_count, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 2) != 0, $urandom(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end

        model_ok = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bufor_wyniku.md
BUFOR_WYNIKU -- requirements
Module: bufor_wyniku

Interface
REQ-001 Parameter BITS, default 32, data width of the converted result word; SHALL match the BITS of the upstream conversion stage.
REQ-002 Parameter CNT_W, default 8, width of the error counter.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  upstream word present on i_result/i_error.
REQ-006 i_result  input  BITS  converted word from the conversion stage (its o_result).
REQ-007 i_error  input  1  error flag from the conversion stage (its o_error).
REQ-008 o_ready  output  1  buffer can accept a word this cycle.
REQ-009 o_valid  output  1  head word available downstream.
REQ-010 i_ready  input  1  downstream accepts the head word this cycle.
REQ-011 o_result  output  BITS  head word.
REQ-012 o_error  output  1  error flag of the head word.
REQ-013 o_err_count  output  CNT_W  saturating count of accepted words with error flag set.

Function
REQ-014 Block SHALL be a 2-entry, order-preserving FIFO (skid buffer) between the combinational conversion stage and the downstream consumer.
REQ-015 Push SHALL occur on a rising edge where i_valid && o_ready; pop SHALL occur where o_valid && i_ready.
REQ-016 o_ready SHALL equal (occupancy < 2), registered-state based, with no combinational path from i_ready.
REQ-017 o_valid SHALL equal (occupancy > 0).
REQ-018 Occupancy state SHALL be one of EMPTY(0), ONE(1), FULL(2).
REQ-019 Transitions: EMPTY --push--> ONE; ONE --push only--> FULL; ONE --pop only--> EMPTY; ONE --push and pop--> ONE; FULL --pop--> ONE; all other cases hold state.
REQ-020 Latency: a word pushed into EMPTY SHALL appear on o_result/o_error with o_valid=1 in the next cycle.
REQ-021 In ONE, a simultaneous push and pop SHALL present the new word as head on the next cycle, with no bubble and no loss.
REQ-022 In FULL, i_valid SHALL be ignored; no overwrite.
REQ-023 o_result SHALL be 0 and o_error SHALL be 0 whenever o_valid=0.
REQ-024 Head o_result/o_error SHALL stay stable while o_valid=1 and i_ready=0.
REQ-025 o_err_count SHALL increment by 1 on each push with i_error=1, SHALL saturate at 2^CNT_W-1, and SHALL never wrap.
REQ-026 A word with i_error=1 SHALL still be buffered and forwarded unchanged; the flag travels with its word.
REQ-027 Internal read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-028 While i_rst=1 at a rising edge: occupancy -> EMPTY, pointers -> 0, o_err_count -> 0; storage contents need not be cleared.
REQ-029 Reset SHALL take priority over simultaneous push/pop; a word offered during the reset cycle SHALL be dropped and not counted.
REQ-030 Reset values: o_valid=0, o_ready=1, o_result=0, o_error=0, o_err_count=0.
REQ-031 Reset asserted mid-operation (ONE or FULL) SHALL discard all buffered words.

Structure
REQ-032 Shared package konwersja_pkg SHALL hold the BITS default, CNT_W default and the occupancy enum typedef (EMPTY/ONE/FULL).
REQ-033 The saturating error counter SHALL be a sub-module licznik_bledow (parameter CNT_W; inputs i_clk, i_rst, i_inc; output o_count).

Verification
REQ-034 Reset then idle -> o_valid=0, o_ready=1, o_result=0, o_err_count=0.
REQ-035 Push 0x0000_0005 into EMPTY with i_ready=1 -> next cycle o_result=0x0000_0005, o_valid=1; following cycle o_valid=0.
REQ-036 i_ready=0, push 0xAAAA_AAAA then 0x5555_5555 -> o_ready=0, third word 0x1234_5678 ignored; release i_ready -> outputs 0xAAAA_AAAA, then 0x5555_5555, then o_valid=0.
REQ-037 Occupancy ONE, simultaneous push 0x0000_00FF and pop -> occupancy stays ONE, head=0x0000_00FF next cycle.
REQ-038 Push 300 words with i_error=1 (negative-zero input 0x8000_0000 upstream) -> o_err_count stops at 255; every word is still delivered with o_error=1.
REQ-039 Occupancy FULL, assert i_rst one cycle with i_valid=1, i_error=1 -> o_valid=0, o_ready=1, o_err_count=0 after the edge.
